// File: rtl/sdrc_responder_if.sv
// SDRC command/data bus between the cache (initiator) and a memory responder.
// Signal names match the SDRC controller IP so either side can be swapped in.
interface sdrc_responder_if;
    logic        I_sdrc_cmd_en;
    logic [2:0]  I_sdrc_cmd;
    logic        I_sdrc_precharge_ctrl;
    logic        I_sdram_power_down;
    logic        I_sdram_selfrefresh;
    logic [20:0] I_sdrc_addr;
    logic [3:0]  I_sdrc_dqm;
    logic [31:0] I_sdrc_data;
    logic [7:0]  I_sdrc_data_len;
    logic [31:0] O_sdrc_data;
    logic        O_sdrc_init_done;
    logic        O_sdrc_cmd_ack;
    logic        protocol_error;

    modport master (
        output I_sdrc_cmd_en, I_sdrc_cmd, I_sdrc_precharge_ctrl, I_sdram_power_down,
               I_sdram_selfrefresh, I_sdrc_addr, I_sdrc_dqm, I_sdrc_data, I_sdrc_data_len,
        input  O_sdrc_data, O_sdrc_init_done, O_sdrc_cmd_ack, protocol_error
    );

    modport slave (
        input  I_sdrc_cmd_en, I_sdrc_cmd, I_sdrc_precharge_ctrl, I_sdram_power_down,
               I_sdram_selfrefresh, I_sdrc_addr, I_sdrc_dqm, I_sdrc_data, I_sdrc_data_len,
        output O_sdrc_data, O_sdrc_init_done, O_sdrc_cmd_ack, protocol_error
    );
endinterface

// File: rtl/sdrc_responder.sv
// SDRC command responder backed by on-chip block RAM: refresh/activate ack,
// fixed read latency, one data word per cycle on read and write bursts.
module sdrc_responder #(
    parameter int MemoryWordBitWidth = 12,
    parameter int RamAddressingMode  = 0,
    parameter int ReadLatency        = 3,
    parameter int InitCycles         = 16
) (
    input  logic             clk,
    input  logic             rst,
    sdrc_responder_if.slave  sdrc
);
    localparam int unsigned Depth = 1 << MemoryWordBitWidth;
    localparam int unsigned Shift = 2 - RamAddressingMode;

    typedef logic [MemoryWordBitWidth-1:0] idx_t;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_READ_WAIT,
        ST_READ_BURST,
        ST_WRITE_BURST
    } state_t;

    logic [31:0] r_mem [0:Depth-1];

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_init_cnt;
    logic        r_init_done;
    logic        r_ref_pend;
    logic        r_ack;
    logic        r_err;
    idx_t        r_idx;
    logic [7:0]  r_remain;
    logic [3:0]  r_wait;
    logic [31:0] r_data;

    logic        w_is_ref, w_is_act, w_is_wr, w_is_rd, w_valid;
    logic [20:0] w_addr_word;
    idx_t        w_start_idx;
    logic        w_init_last;
    logic        w_mem_we;
    idx_t        w_mem_idx;
    logic        w_mem_rd;
    logic        w_ack_next;
    logic        w_err_set;
    logic        w_ref_latch;
    logic        w_unused;

    assign w_is_ref = (sdrc.I_sdrc_cmd == 3'b001);
    assign w_is_act = (sdrc.I_sdrc_cmd == 3'b011);
    assign w_is_wr  = (sdrc.I_sdrc_cmd == 3'b100);
    assign w_is_rd  = (sdrc.I_sdrc_cmd == 3'b101);
    assign w_valid  = w_is_ref | w_is_act | w_is_wr | w_is_rd;

    // Address bits above the backing-store depth are dropped; bursts wrap.
    assign w_addr_word = sdrc.I_sdrc_addr >> Shift;
    assign w_start_idx = w_addr_word[MemoryWordBitWidth-1:0];
    assign w_init_last = (r_init_cnt == 8'(InitCycles - 1));

    assign w_unused = ^{sdrc.I_sdrc_precharge_ctrl, sdrc.I_sdram_power_down,
                        sdrc.I_sdram_selfrefresh, sdrc.I_sdrc_addr};

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_INIT;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_INIT: if (w_init_last) w_next = ST_IDLE;
            ST_IDLE: begin
                if (sdrc.I_sdrc_cmd_en && w_is_wr && sdrc.I_sdrc_data_len != 8'd0)
                    w_next = ST_WRITE_BURST;
                else if (sdrc.I_sdrc_cmd_en && w_is_rd)
                    w_next = ST_READ_WAIT;
            end
            ST_READ_WAIT: if (r_wait == 4'd0)
                w_next = (r_remain == 8'd0) ? ST_IDLE : ST_READ_BURST;
            ST_READ_BURST:  if (r_remain == 8'd1) w_next = ST_IDLE;
            ST_WRITE_BURST: if (r_remain == 8'd1) w_next = ST_IDLE;
            default: w_next = ST_INIT;
        endcase
    end

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_idx   = r_idx;
        w_mem_rd    = 1'b0;
        w_ack_next  = 1'b0;
        w_err_set   = 1'b0;
        w_ref_latch = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (sdrc.I_sdrc_cmd_en) begin
                    if (w_is_ref) w_ref_latch = 1'b1;
                    else          w_err_set   = 1'b1;
                end
                // A refresh seen during init is acked in the first Idle cycle.
                if (w_init_last)
                    w_ack_next = r_ref_pend | (sdrc.I_sdrc_cmd_en & w_is_ref);
            end
            ST_IDLE: begin
                if (sdrc.I_sdrc_cmd_en) begin
                    w_ack_next = w_is_ref | w_is_act;
                    w_err_set  = ~w_valid;
                    if (w_is_wr) begin
                        w_mem_we  = 1'b1;
                        w_mem_idx = w_start_idx;
                    end
                end
            end
            ST_READ_WAIT: begin
                w_err_set = sdrc.I_sdrc_cmd_en;
                w_mem_rd  = (r_wait == 4'd0);
            end
            ST_READ_BURST: begin
                w_err_set = sdrc.I_sdrc_cmd_en;
                w_mem_rd  = 1'b1;
            end
            ST_WRITE_BURST: begin
                w_err_set = sdrc.I_sdrc_cmd_en;
                w_mem_we  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
            r_ref_pend  <= 1'b0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_idx       <= '0;
            r_remain    <= '0;
            r_wait      <= '0;
            r_data      <= '0;
        end else begin
            r_ack <= w_ack_next;
            if (w_err_set) r_err <= 1'b1;
            case (r_state)
                ST_INIT: begin
                    r_init_cnt <= r_init_cnt + 8'd1;
                    r_ref_pend <= (r_ref_pend | w_ref_latch) & ~w_init_last;
                    if (w_init_last) r_init_done <= 1'b1;
                end
                ST_IDLE: begin
                    if (sdrc.I_sdrc_cmd_en && w_is_wr) begin
                        r_idx    <= w_start_idx + idx_t'(1);
                        r_remain <= sdrc.I_sdrc_data_len;
                    end else if (sdrc.I_sdrc_cmd_en && w_is_rd) begin
                        r_idx    <= w_start_idx;
                        r_remain <= sdrc.I_sdrc_data_len;
                        r_wait   <= 4'(ReadLatency - 1);
                    end
                end
                ST_READ_WAIT: if (r_wait != 4'd0) r_wait <= r_wait - 4'd1;
                ST_READ_BURST: r_remain <= r_remain - 8'd1;
                ST_WRITE_BURST: begin
                    r_idx    <= r_idx + idx_t'(1);
                    r_remain <= r_remain - 8'd1;
                end
                default: ;
            endcase
            if (w_mem_rd) begin
                r_data <= r_mem[r_idx];
                r_idx  <= r_idx + idx_t'(1);
            end
        end
    end

    // Backing store has no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (w_mem_we && !rst) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (!sdrc.I_sdrc_dqm[b])
                    r_mem[w_mem_idx][8*b +: 8] <= sdrc.I_sdrc_data[8*b +: 8];
            end
        end
    end

    assign sdrc.O_sdrc_data      = r_data;
    assign sdrc.O_sdrc_init_done = r_init_done;
    assign sdrc.O_sdrc_cmd_ack   = r_ack;
    assign sdrc.protocol_error   = r_err;
endmodule

// File: tb/tb_sdrc_responder.sv
// Directed self-checking bench for sdrc_responder: init, refresh during init,
// burst write/read, byte masking, wrap-around, protocol errors and mid-burst reset.
module tb_sdrc_responder;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sdrc_responder_if bus ();

    sdrc_responder #(
        .MemoryWordBitWidth(12),
        .RamAddressingMode (0),
        .ReadLatency       (3),
        .InitCycles        (16)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .sdrc (bus)
    );

    localparam logic [2:0] CMD_REF = 3'b001;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_RD  = 3'b101;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one command for the edge E0; returns 1 ns after E0 with cmd_en low.
    task automatic issue(input logic [2:0] cmd, input logic [20:0] addr, input logic [7:0] len,
                         input logic [31:0] data, input logic [3:0] dqm);
        bus.I_sdrc_cmd_en   = 1'b1;
        bus.I_sdrc_cmd      = cmd;
        bus.I_sdrc_addr     = addr;
        bus.I_sdrc_data_len = len;
        bus.I_sdrc_data     = data;
        bus.I_sdrc_dqm      = dqm;
        tick();
        bus.I_sdrc_cmd_en   = 1'b0;
        bus.I_sdrc_dqm      = 4'b0000;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.I_sdrc_cmd_en         = 1'b0;
        bus.I_sdrc_cmd            = 3'b000;
        bus.I_sdrc_precharge_ctrl = 1'b0;
        bus.I_sdram_power_down    = 1'b0;
        bus.I_sdram_selfrefresh   = 1'b0;
        bus.I_sdrc_addr           = '0;
        bus.I_sdrc_dqm            = '0;
        bus.I_sdrc_data           = '0;
        bus.I_sdrc_data_len       = '0;

        // Reset state and init delay
        repeat (3) tick();
        check("rst_data", bus.O_sdrc_data, 32'h0);
        check("rst_init_done", 32'(bus.O_sdrc_init_done), 32'h0);
        check("rst_ack", 32'(bus.O_sdrc_cmd_ack), 32'h0);
        check("rst_err", 32'(bus.protocol_error), 32'h0);
        rst = 1'b0;
        repeat (15) tick();
        check("init_not_yet", 32'(bus.O_sdrc_init_done), 32'h0);
        tick();
        check("init_done_16", 32'(bus.O_sdrc_init_done), 32'h1);
        check("init_no_ack", 32'(bus.O_sdrc_cmd_ack), 32'h0);
        check("init_no_err", 32'(bus.protocol_error), 32'h0);

        // Refresh sampled on the first edge after reset release
        rst = 1'b1;
        tick();
        rst = 1'b0;
        issue(CMD_REF, 21'h0, 8'd0, 32'h0, 4'b0000);
        repeat (14) tick();
        check("ref_init_no_ack", 32'(bus.O_sdrc_cmd_ack), 32'h0);
        check("ref_init_not_done", 32'(bus.O_sdrc_init_done), 32'h0);
        tick();
        check("ref_ack_first_idle", 32'(bus.O_sdrc_cmd_ack), 32'h1);
        check("ref_done", 32'(bus.O_sdrc_init_done), 32'h1);
        tick();
        check("ref_ack_one_cycle", 32'(bus.O_sdrc_cmd_ack), 32'h0);
        check("ref_no_err", 32'(bus.protocol_error), 32'h0);

        // Cache eviction: activate, burst write 8 words, burst read back
        issue(CMD_ACT, 21'h000100, 8'd0, 32'h0, 4'b0000);
        check("act_ack", 32'(bus.O_sdrc_cmd_ack), 32'h1);
        tick();
        check("act_ack_drop", 32'(bus.O_sdrc_cmd_ack), 32'h0);
        issue(CMD_WR, 21'h000100, 8'd7, 32'h11111111, 4'b0000);
        for (int k = 1; k < 8; k++) begin
            bus.I_sdrc_data = 32'h11111111 * (k + 1);
            tick();
        end
        repeat (4) tick();
        issue(CMD_RD, 21'h000100, 8'd7, 32'h0, 4'b0000);
        tick();
        tick();
        check("rd_lat_before", bus.O_sdrc_data, 32'h0);
        tick();
        check("rd_word0", bus.O_sdrc_data, 32'h11111111);
        for (int k = 1; k < 8; k++) begin
            tick();
            check($sformatf("rd_word%0d", k), bus.O_sdrc_data, 32'h11111111 * (k + 1));
        end
        tick();
        check("rd_hold_last", bus.O_sdrc_data, 32'h88888888);
        check("rd_no_err", 32'(bus.protocol_error), 32'h0);

        // Byte mask
        issue(CMD_WR, 21'h000040, 8'd0, 32'hAABBCCDD, 4'b0000);
        issue(CMD_WR, 21'h000040, 8'd0, 32'h11223344, 4'b0101);
        issue(CMD_RD, 21'h000040, 8'd0, 32'h0, 4'b0000);
        repeat (3) tick();
        check("mask_merge", bus.O_sdrc_data, 32'h11BB33DD);

        // Wrap-around at the top of the backing store
        issue(CMD_WR, 21'h003FF8, 8'd3, 32'd1, 4'b0000);
        for (int k = 2; k <= 4; k++) begin
            bus.I_sdrc_data = 32'(k);
            tick();
        end
        issue(CMD_RD, 21'h003FF8, 8'd3, 32'h0, 4'b0000);
        repeat (3) tick();
        check("wrap_rd0", bus.O_sdrc_data, 32'd1);
        for (int k = 2; k <= 4; k++) begin
            tick();
            check($sformatf("wrap_rd%0d", k - 1), bus.O_sdrc_data, 32'(k));
        end
        issue(CMD_RD, 21'h000000, 8'd0, 32'h0, 4'b0000);
        repeat (3) tick();
        check("wrap_idx0", bus.O_sdrc_data, 32'd3);
        issue(CMD_RD, 21'h010004, 8'd0, 32'h0, 4'b0000);
        repeat (3) tick();
        check("high_addr_discard", bus.O_sdrc_data, 32'd4);
        check("wrap_no_err", 32'(bus.protocol_error), 32'h0);

        // Write command during a read burst is rejected
        issue(CMD_RD, 21'h000100, 8'd7, 32'h0, 4'b0000);
        tick();
        issue(CMD_WR, 21'h000100, 8'd0, 32'hDEADBEEF, 4'b0000);
        check("err_set", 32'(bus.protocol_error), 32'h1);
        tick();
        check("err_rd_word0", bus.O_sdrc_data, 32'h11111111);
        for (int k = 1; k < 8; k++) begin
            tick();
            check($sformatf("err_rd_word%0d", k), bus.O_sdrc_data, 32'h11111111 * (k + 1));
        end
        tick();
        check("err_no_ack", 32'(bus.O_sdrc_cmd_ack), 32'h0);
        issue(CMD_RD, 21'h000100, 8'd0, 32'h0, 4'b0000);
        repeat (3) tick();
        check("err_write_ignored", bus.O_sdrc_data, 32'h11111111);

        // Reset in the middle of a read burst
        issue(CMD_RD, 21'h000104, 8'd7, 32'h0, 4'b0000);
        repeat (4) tick();
        check("pre_rst_word1", bus.O_sdrc_data, 32'h33333333);
        rst = 1'b1;
        tick();
        check("mid_rst_init_done", 32'(bus.O_sdrc_init_done), 32'h0);
        check("mid_rst_err", 32'(bus.protocol_error), 32'h0);
        check("mid_rst_data", bus.O_sdrc_data, 32'h0);
        rst = 1'b0;
        repeat (16) tick();
        check("post_rst_init", 32'(bus.O_sdrc_init_done), 32'h1);
        check("post_rst_data_idle", bus.O_sdrc_data, 32'h0);
        issue(CMD_RD, 21'h000100, 8'd1, 32'h0, 4'b0000);
        repeat (3) tick();
        check("retained_w0", bus.O_sdrc_data, 32'h11111111);
        tick();
        check("retained_w1", bus.O_sdrc_data, 32'h22222222);
        tick();

        // Undefined command code in Idle
        issue(3'b110, 21'h0, 8'd0, 32'h0, 4'b0000);
        check("undef_err", 32'(bus.protocol_error), 32'h1);
        check("undef_no_ack", 32'(bus.O_sdrc_cmd_ack), 32'h0);
        check("undef_data_hold", bus.O_sdrc_data, 32'h22222222);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
